// File: rtl/out_sram_drain.sv
`default_nettype none
// ============================================================================
// Module   : out_sram_drain
// Purpose  : Drains PE-array result rows into the output SRAM with tile-aware
//            addressing, lane write masks for partial tiles and completion.
// Revision : 1.0
// ============================================================================
module out_sram_drain #(
    parameter int OUT_SRAM_AWIDTH        = 10,
    parameter int LANE_BWIDTH            = 32,
    parameter int PE_ARRAY_NUM_ROWS      = 32,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
    parameter int PE_ARRAY_NUM_COLS      = 32,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
    parameter int MAX_M_SIZE_LOG2        = 9,
    parameter int MAX_N_SIZE_LOG2        = 9
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       START,
    input  logic                                       STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]                 M_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]                 N_SIZE_in,
    input  logic                                       ROW_VALID_in,
    input  logic [PE_ARRAY_NUM_COLS*LANE_BWIDTH-1:0]   ROW_DATA_in,
    output logic                                       ROW_READY_out,
    output logic                                       OUT_SRAM_WEN_out,
    output logic [OUT_SRAM_AWIDTH-1:0]                 OUT_SRAM_ADDR_out,
    output logic [PE_ARRAY_NUM_COLS*LANE_BWIDTH-1:0]   OUT_SRAM_DATA_out,
    output logic [PE_ARRAY_NUM_COLS*LANE_BWIDTH-1:0]   OUT_SRAM_BE_out,
    output logic                                       DONE_out,
    output logic                                       IS_FINISHED_out
);

    localparam int c_DW     = PE_ARRAY_NUM_COLS * LANE_BWIDTH;
    localparam int c_TM_W   = MAX_M_SIZE_LOG2 - PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam int c_TN_W   = MAX_N_SIZE_LOG2 - PE_ARRAY_NUM_COLS_LOG2 + 1;
    localparam int c_GROW_W = c_TM_W + PE_ARRAY_NUM_ROWS_LOG2;
    localparam int c_PROD_W = c_GROW_W + c_TN_W;
    localparam int c_SUM_W  = c_PROD_W + 1;
    localparam int c_COL_W  = c_TN_W + PE_ARRAY_NUM_COLS_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [MAX_M_SIZE_LOG2-1:0]      r_m_size;
    logic [MAX_N_SIZE_LOG2-1:0]      r_n_size;
    logic [c_TM_W-1:0]               r_m_tiles;
    logic [c_TN_W-1:0]               r_n_tiles;
    logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] r_r;
    logic [c_TN_W-1:0]               r_tn;
    logic [c_TM_W-1:0]               r_tm;
    logic                            r_wen;
    logic [OUT_SRAM_AWIDTH-1:0]      r_addr;
    logic [c_DW-1:0]                 r_data;
    logic [c_DW-1:0]                 r_be;
    logic                            r_finished;

    logic                            w_ready;
    logic                            w_accept;
    logic                            w_last_beat;
    logic [c_GROW_W-1:0]             w_grow;
    logic [c_PROD_W-1:0]             w_prod;
    logic [c_SUM_W-1:0]              w_addr_full;
    logic                            w_in_range;
    logic [c_COL_W-1:0]              w_col_base;
    logic [PE_ARRAY_NUM_COLS-1:0]    w_lane_en;
    logic [c_DW-1:0]                 w_be;
    logic [MAX_M_SIZE_LOG2:0]        w_m_ext;
    logic [MAX_N_SIZE_LOG2:0]        w_n_ext;

    assign w_ready  = (r_state == S_DRAIN) && !STALL;
    assign w_accept = ROW_VALID_in && w_ready;

    // Tile counts are ceil(size / array dimension), taken from the live inputs at START.
    assign w_m_ext = {1'b0, M_SIZE_in} + (MAX_M_SIZE_LOG2+1)'(PE_ARRAY_NUM_ROWS - 1);
    assign w_n_ext = {1'b0, N_SIZE_in} + (MAX_N_SIZE_LOG2+1)'(PE_ARRAY_NUM_COLS - 1);

    assign w_last_beat = (r_r  == PE_ARRAY_NUM_ROWS_LOG2'(PE_ARRAY_NUM_ROWS - 1))
                      && (r_tn == r_n_tiles - c_TN_W'(1))
                      && (r_tm == r_m_tiles - c_TM_W'(1));

    // Full-width arithmetic up to the final truncation so the address wraps only at the port.
    assign w_grow      = {r_tm, r_r};
    assign w_prod      = c_PROD_W'(w_grow) * c_PROD_W'(r_n_tiles);
    assign w_addr_full = {1'b0, w_prod} + c_SUM_W'(r_tn);
    assign w_in_range  = w_grow < c_GROW_W'(r_m_size);
    assign w_col_base  = {r_tn, PE_ARRAY_NUM_COLS_LOG2'(0)};

    generate
        for (genvar c = 0; c < PE_ARRAY_NUM_COLS; c++) begin : g_lane
            assign w_lane_en[c] = (w_col_base + c_COL_W'(c)) < c_COL_W'(r_n_size);
            assign w_be[c*LANE_BWIDTH +: LANE_BWIDTH] = {LANE_BWIDTH{w_lane_en[c]}};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        DONE_out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    if ((M_SIZE_in == '0) || (N_SIZE_in == '0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DONE_out    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m_size   <= '0;
            r_n_size   <= '0;
            r_m_tiles  <= '0;
            r_n_tiles  <= '0;
            r_r        <= '0;
            r_tn       <= '0;
            r_tm       <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_finished <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if ((r_state == S_IDLE) && START) begin
                r_m_size   <= M_SIZE_in;
                r_n_size   <= N_SIZE_in;
                r_m_tiles  <= c_TM_W'(w_m_ext >> PE_ARRAY_NUM_ROWS_LOG2);
                r_n_tiles  <= c_TN_W'(w_n_ext >> PE_ARRAY_NUM_COLS_LOG2);
                r_r        <= '0;
                r_tn       <= '0;
                r_tm       <= '0;
                r_finished <= 1'b0;
            end
            if (w_state_nxt == S_DONE) begin
                r_finished <= 1'b1;
            end
            if (w_accept) begin
                // Row index is innermost, then column tile, then row tile.
                if (r_r == PE_ARRAY_NUM_ROWS_LOG2'(PE_ARRAY_NUM_ROWS - 1)) begin
                    r_r <= '0;
                    if (r_tn == r_n_tiles - c_TN_W'(1)) begin
                        r_tn <= '0;
                        r_tm <= r_tm + c_TM_W'(1);
                    end else begin
                        r_tn <= r_tn + c_TN_W'(1);
                    end
                end else begin
                    r_r <= r_r + PE_ARRAY_NUM_ROWS_LOG2'(1);
                end
                if (w_in_range) begin
                    r_wen  <= 1'b1;
                    r_addr <= OUT_SRAM_AWIDTH'(w_addr_full);
                    r_data <= ROW_DATA_in;
                    r_be   <= w_be;
                end
            end
        end
    end

    assign ROW_READY_out     = w_ready;
    assign OUT_SRAM_WEN_out  = r_wen;
    assign OUT_SRAM_ADDR_out = r_addr;
    assign OUT_SRAM_DATA_out = r_data;
    assign OUT_SRAM_BE_out   = r_be;
    assign IS_FINISHED_out   = r_finished;

endmodule
`default_nettype wire
